// File: rtl/cdb_result_buffer.sv
// Per-functional-unit CDB result queue: holds completed packets in arrival order
// and presents the oldest to the scheduler over a valid/yummi handshake.
package cdb_pkg;
    parameter int ROB_IDX_W = 5;
    parameter int DATA_W    = 32;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] dest_ROB_entry;
        logic [DATA_W-1:0]    result;
        logic                 branch_result;
    } CDB_packet_t;
endpackage

module cdb_result_buffer
    import cdb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       fu_valid_i,
    input  CDB_packet_t                fu_packet_i,
    output logic                       fu_ready_o,
    output logic                       valid_out,
    output CDB_packet_t                packet_out,
    input  logic                       yummi_in,
    output logic                       starve_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [ST_W-1:0]  starve_cnt;
    CDB_packet_t      mem [DEPTH];

    logic push;
    logic pop;

    // Ready and valid come only from registered count, so no yummi -> ready path.
    assign fu_ready_o = (count != CNT_W'(DEPTH));
    assign valid_out  = (count != '0);
    assign packet_out = mem[head];
    assign count_o    = count;
    assign starve_o   = (starve_cnt == ST_W'(STARVE_LIMIT));

    assign push = fu_valid_i && fu_ready_o && !flush_i;
    assign pop  = yummi_in && valid_out && !flush_i;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[tail] <= fu_packet_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= ptr_next(tail);
            end
            if (pop) begin
                head <= ptr_next(head);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (flush_i || pop || !valid_out) begin
            starve_cnt <= '0;
        end else if (starve_cnt != ST_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + ST_W'(1);
        end
    end

endmodule

// File: tb/tb_cdb_result_buffer.sv
// Bench for cdb_result_buffer: directed vector table, corner sequences and a
// randomized run against a queue-based reference, on DEPTH=4 and DEPTH=3 instances.
module tb_cdb_result_buffer;
    import cdb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        fu_valid;
    CDB_packet_t fu_packet;
    logic        yummi;

    logic        rdy4, v4, s4;
    CDB_packet_t p4;
    logic [2:0]  c4;
    logic        rdy3, v3, s3;
    CDB_packet_t p3;
    logic [1:0]  c3;

    int errors = 0;
    int checks = 0;

    CDB_packet_t q4[$];
    CDB_packet_t q3[$];
    int          sc4 = 0;
    int          sc3 = 0;

    always #5 clk = ~clk;

    cdb_result_buffer #(.DEPTH(4), .STARVE_LIMIT(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .fu_valid_i(fu_valid),
        .fu_packet_i(fu_packet), .fu_ready_o(rdy4), .valid_out(v4),
        .packet_out(p4), .yummi_in(yummi), .starve_o(s4), .count_o(c4)
    );

    cdb_result_buffer #(.DEPTH(3), .STARVE_LIMIT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .fu_valid_i(fu_valid),
        .fu_packet_i(fu_packet), .fu_ready_o(rdy3), .valid_out(v3),
        .packet_out(p3), .yummi_in(yummi), .starve_o(s3), .count_o(c3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic CDB_packet_t mk(input int d);
        CDB_packet_t p;
        p.dest_ROB_entry = ROB_IDX_W'(d);
        p.result         = (32'(d) * 32'h0101_0101) ^ 32'h5A00_0000;
        p.branch_result  = d[0];
        return p;
    endfunction

    // Reference: an ordered queue of held packets plus a count of ungranted cycles.
    task automatic model_tick();
        CDB_packet_t q[$];
        int sc, depth, lim;
        bit had, room, popped;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin q = q4; sc = sc4; depth = 4; lim = 8; end
            else        begin q = q3; sc = sc3; depth = 3; lim = 3; end
            if (!rst_n || flush) begin
                q.delete();
                sc = 0;
            end else begin
                had    = (q.size() != 0);
                room   = (q.size() != depth);
                popped = yummi && had;
                if (popped) void'(q.pop_front());
                if (fu_valid && room) q.push_back(fu_packet);
                if (popped || !had) sc = 0;
                else if (sc < lim) sc++;
            end
            if (i == 0) begin q4 = q; sc4 = sc; end
            else        begin q3 = q; sc3 = sc; end
        end
    endtask

    task automatic check_models();
        chk("m4_count", 64'(c4), 64'(q4.size()));
        chk("m4_valid", 64'(v4), 64'(q4.size() != 0));
        chk("m4_ready", 64'(rdy4), 64'(q4.size() != 4));
        chk("m4_starve", 64'(s4), 64'(sc4 == 8));
        if (q4.size() != 0) chk("m4_head", 64'(p4), 64'(q4[0]));
        chk("m3_count", 64'(c3), 64'(q3.size()));
        chk("m3_valid", 64'(v3), 64'(q3.size() != 0));
        chk("m3_ready", 64'(rdy3), 64'(q3.size() != 3));
        chk("m3_starve", 64'(s3), 64'(sc3 == 3));
        if (q3.size() != 0) chk("m3_head", 64'(p3), 64'(q3[0]));
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
        check_models();
    endtask

    typedef struct {
        bit f; bit v; int d; bit y;
        int cnt; bit vld; int head; bit rdy;
    } vec_t;

    vec_t tbl[19];
    int   got[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected DEPTH=4 state after each edge: count, valid, head dest, ready.
        tbl[0]  = '{0, 1, 1,  0, 1, 1, 1,  1};
        tbl[1]  = '{0, 1, 2,  0, 2, 1, 1,  1};
        tbl[2]  = '{0, 1, 3,  0, 3, 1, 1,  1};
        tbl[3]  = '{0, 1, 4,  0, 4, 1, 1,  0};
        tbl[4]  = '{0, 1, 5,  0, 4, 1, 1,  0};
        tbl[5]  = '{0, 0, 0,  1, 3, 1, 2,  1};
        tbl[6]  = '{0, 0, 0,  1, 2, 1, 3,  1};
        tbl[7]  = '{0, 0, 0,  1, 1, 1, 4,  1};
        tbl[8]  = '{0, 0, 0,  1, 0, 0, 0,  1};
        tbl[9]  = '{0, 1, 7,  0, 1, 1, 7,  1};
        tbl[10] = '{0, 1, 8,  0, 2, 1, 7,  1};
        tbl[11] = '{0, 1, 9,  1, 2, 1, 8,  1};
        tbl[12] = '{0, 1, 10, 0, 3, 1, 8,  1};
        tbl[13] = '{0, 1, 11, 0, 4, 1, 8,  0};
        tbl[14] = '{0, 1, 12, 1, 3, 1, 9,  1};
        tbl[15] = '{1, 1, 13, 1, 0, 0, 0,  1};
        tbl[16] = '{0, 1, 20, 0, 1, 1, 20, 1};
        tbl[17] = '{0, 0, 0,  1, 0, 0, 0,  1};
        tbl[18] = '{0, 0, 0,  1, 0, 0, 0,  1};

        rst_n = 1'b0; flush = 1'b0; fu_valid = 1'b0; fu_packet = '0; yummi = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_valid", 64'(v4), 64'(0));
        chk("rst_ready", 64'(rdy4), 64'(1));
        chk("rst_count", 64'(c4), 64'(0));
        chk("rst_starve", 64'(s4), 64'(0));
        chk("rst_packet", 64'(p4), 64'(0));

        foreach (tbl[i]) begin
            flush = tbl[i].f; fu_valid = tbl[i].v; fu_packet = mk(tbl[i].d); yummi = tbl[i].y;
            step();
            chk($sformatf("tbl%0d_count", i), 64'(c4), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d_valid", i), 64'(v4), 64'(tbl[i].vld));
            chk($sformatf("tbl%0d_ready", i), 64'(rdy4), 64'(tbl[i].rdy));
            if (tbl[i].vld) chk($sformatf("tbl%0d_head", i), 64'(p4), 64'(mk(tbl[i].head)));
        end
        flush = 1'b0; fu_valid = 1'b0; yummi = 1'b0;

        // Streaming through the DEPTH=3 instance wraps both pointers several times.
        for (int i = 1; i <= 11; i++) begin
            fu_valid  = (i <= 10);
            fu_packet = mk(i);
            yummi     = (i >= 2);
            if (yummi && v3) got.push_back(int'(p3.dest_ROB_entry));
            step();
            chk("wrap_count_le1", 64'(c3 <= 2'd1), 64'(1));
        end
        fu_valid = 1'b0; yummi = 1'b0;
        chk("wrap_num", 64'(got.size()), 64'(10));
        foreach (got[k]) chk($sformatf("wrap_order%0d", k), 64'(got[k]), 64'(k + 1));

        fu_valid = 1'b1; fu_packet = mk(30);
        step();
        fu_valid = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            step();
            chk($sformatf("starve_c%0d", i), 64'(s4), 64'(i >= 8));
        end
        yummi = 1'b1;
        step();
        yummi = 1'b0;
        chk("starve_clear", 64'(s4), 64'(0));
        chk("starve_empty", 64'(v4), 64'(0));

        fu_valid = 1'b1; fu_packet = mk(21);
        step();
        fu_packet = mk(22);
        step();
        fu_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_count", 64'(c4), 64'(0));
        chk("async_valid", 64'(v4), 64'(0));
        chk("async_ready", 64'(rdy4), 64'(1));
        chk("async_packet", 64'(p4), 64'(0));
        q4.delete(); q3.delete(); sc4 = 0; sc3 = 0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        for (int c = 0; c < 3000; c++) begin
            int ph;
            ph        = (c / 500) % 3;
            flush     = ($urandom_range(0, 31) == 0);
            fu_valid  = ($urandom_range(0, 3) != 0);
            fu_packet = CDB_packet_t'({$urandom, $urandom});
            case (ph)
                0:       yummi = ($urandom_range(0, 1) == 0);
                1:       yummi = ($urandom_range(0, 7) == 0);
                default: yummi = ($urandom_range(0, 7) != 0);
            endcase
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
